// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over one shared ALU and one unified memory port.
package multicycle_pkg;
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;
endpackage

module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output imm_src_t   imm_src,
    output logic       illegal
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, EXECU, ALUWB, BRANCH, JAL, ERROR
    } state_t;

    state_t state;

    // Only R-type with funct7b5 set subtracts; addi ignores instr[30].
    function automatic logic [2:0] alu_decode(input logic is_r, input logic [2:0] f3,
                                              input logic f7b5);
        case (f3)
            3'b000:  alu_decode = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decode = ALU_SLT;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BRANCH:   imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            OP_LUI:      imm_src = IMM_U;
            default:     imm_src = IMM_I;
        endcase
    end

    // State register; reset abandons any in-flight instruction or stalled access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECR;
                        OP_I:         state <= EXECI;
                        OP_BRANCH:    state <= BRANCH;
                        OP_JAL:       state <= JAL;
                        OP_LUI:       state <= EXECU;
                        default:      state <= ERROR;
                    endcase
                end
                MEMADR:   state <= (op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                EXECU:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                JAL:      state <= ALUWB;
                ERROR:    state <= ERROR;
                default:  state <= ERROR;
            endcase
        end
    end

    // Outputs decode from state; reset forces everything idle while it is held.
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = alu_decode(1'b1, funct3, funct7b5);
                end
                EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = alu_decode(1'b0, funct3, funct7b5);
                end
                EXECU: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                end
                ALUWB:  reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = ALU_SUB;
                    pc_write    = zero ^ funct3[0];
                end
                JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                ERROR:   illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// its state sequence and checks the full output word every cycle.
module tb_multicycle_controller;
    import multicycle_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    imm_src_t   imm_src;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] sig;
    assign sig = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_control, illegal};

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected output word assembled field by field from the state tables.
    function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mreq,
                                       input logic mwr, input logic irw, input logic rw,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] alu,
                                       input logic ill);
        mk = {pcw, adr, mreq, mwr, irw, rw, res, a, b, alu, ill};
    endfunction

    localparam logic [15:0] S_IDLE     = 16'h0000;
    localparam logic [15:0] S_FWAIT    = {6'b001000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [15:0] S_FGO      = {6'b101010, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [15:0] S_DECODE   = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0};
    localparam logic [15:0] S_MEMADR   = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0};
    localparam logic [15:0] S_MEMREAD  = {6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] S_MEMWB    = {6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] S_MEMWRITE = {6'b011100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] S_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] S_EXECU    = {6'b000000, 2'b00, 2'b11, 2'b01, 3'b000, 1'b0};
    localparam logic [15:0] S_JAL      = {6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0};
    localparam logic [15:0] S_ERROR    = 16'h0001;

    task automatic applyStimulus(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic rdy);
        reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    endtask

    // Checks mid-cycle, then advances to the next falling edge.
    task automatic checkOutput(input string tag, input logic [15:0] expected);
        #1;
        compared++;
        assert (sig === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, sig, expected);
        end
        @(negedge clk);
    endtask

    task automatic checkImm(input string tag, input imm_src_t expected);
        #1;
        compared++;
        assert (imm_src === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, imm_src, expected);
        end
    endtask

    initial begin
        applyStimulus(1, 7'h00, 3'b000, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset_hold0", S_IDLE);
        checkOutput("reset_hold1", S_IDLE);

        // lw x5, 8(x1): five cycles, writeback only in the last
        applyStimulus(0, 7'b0000011, 3'b010, 0, 0, 1);
        checkImm("lw_imm", IMM_I);
        checkOutput("lw_fetch", S_FGO);
        checkOutput("lw_decode", S_DECODE);
        checkOutput("lw_memadr", S_MEMADR);
        checkOutput("lw_memread", S_MEMREAD);
        checkOutput("lw_memwb", S_MEMWB);

        // sw with a one-cycle fetch stall and three stall cycles in MEMWRITE
        applyStimulus(0, 7'b0100011, 3'b010, 0, 0, 0);
        checkImm("sw_imm", IMM_S);
        checkOutput("sw_fetch_stall", S_FWAIT);
        mem_ready = 1;
        checkOutput("sw_fetch", S_FGO);
        checkOutput("sw_decode", S_DECODE);
        checkOutput("sw_memadr", S_MEMADR);
        mem_ready = 0;
        checkOutput("sw_stall0", S_MEMWRITE);
        checkOutput("sw_stall1", S_MEMWRITE);
        checkOutput("sw_stall2", S_MEMWRITE);
        mem_ready = 1;
        checkOutput("sw_done", S_MEMWRITE);

        // sub x2, x1, x2
        applyStimulus(0, 7'b0110011, 3'b000, 1, 0, 1);
        checkOutput("sub_fetch", S_FGO);
        checkOutput("sub_decode", S_DECODE);
        checkOutput("sub_execr", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
        checkOutput("sub_aluwb", S_ALUWB);

        // or (R-type funct3 110)
        applyStimulus(0, 7'b0110011, 3'b110, 0, 0, 1);
        checkOutput("or_fetch", S_FGO);
        checkOutput("or_decode", S_DECODE);
        checkOutput("or_execr", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b011, 0));
        checkOutput("or_aluwb", S_ALUWB);

        // addi with instr[30] set must still add
        applyStimulus(0, 7'b0010011, 3'b000, 1, 0, 1);
        checkImm("addi_imm", IMM_I);
        checkOutput("addi_fetch", S_FGO);
        checkOutput("addi_decode", S_DECODE);
        checkOutput("addi_execi", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
        checkOutput("addi_aluwb", S_ALUWB);

        // slti and andi
        applyStimulus(0, 7'b0010011, 3'b010, 0, 0, 1);
        checkOutput("slti_fetch", S_FGO);
        checkOutput("slti_decode", S_DECODE);
        checkOutput("slti_execi", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b101, 0));
        checkOutput("slti_aluwb", S_ALUWB);
        applyStimulus(0, 7'b0010011, 3'b111, 0, 0, 1);
        checkOutput("andi_fetch", S_FGO);
        checkOutput("andi_decode", S_DECODE);
        checkOutput("andi_execi", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b010, 0));
        checkOutput("andi_aluwb", S_ALUWB);

        // Branches: beq taken, beq not taken, bne taken
        applyStimulus(0, 7'b1100011, 3'b000, 0, 1, 1);
        checkImm("beq_imm", IMM_B);
        checkOutput("beqt_fetch", S_FGO);
        checkOutput("beqt_decode", S_DECODE);
        checkOutput("beqt_branch", mk(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
        applyStimulus(0, 7'b1100011, 3'b000, 0, 0, 1);
        checkOutput("beqn_fetch", S_FGO);
        checkOutput("beqn_decode", S_DECODE);
        checkOutput("beqn_branch", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
        applyStimulus(0, 7'b1100011, 3'b001, 0, 0, 1);
        checkOutput("bnet_fetch", S_FGO);
        checkOutput("bnet_decode", S_DECODE);
        checkOutput("bnet_branch", mk(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 0));

        // jal then lui
        applyStimulus(0, 7'b1101111, 3'b000, 0, 0, 1);
        checkImm("jal_imm", IMM_J);
        checkOutput("jal_fetch", S_FGO);
        checkOutput("jal_decode", S_DECODE);
        checkOutput("jal_jal", S_JAL);
        checkOutput("jal_aluwb", S_ALUWB);
        applyStimulus(0, 7'b0110111, 3'b000, 0, 0, 1);
        checkImm("lui_imm", IMM_U);
        checkOutput("lui_fetch", S_FGO);
        checkOutput("lui_decode", S_DECODE);
        checkOutput("lui_execu", S_EXECU);
        checkOutput("lui_aluwb", S_ALUWB);

        // Reset while lw is stalled in MEMREAD
        applyStimulus(0, 7'b0000011, 3'b010, 0, 0, 1);
        checkOutput("rlw_fetch", S_FGO);
        checkOutput("rlw_decode", S_DECODE);
        checkOutput("rlw_memadr", S_MEMADR);
        mem_ready = 0;
        checkOutput("rlw_memread_stall", S_MEMREAD);
        reset = 1;
        checkOutput("rlw_in_reset", S_IDLE);
        reset = 0;
        checkOutput("rlw_after_reset", S_FWAIT);

        // Undefined opcode locks in ERROR until reset
        applyStimulus(0, 7'h7F, 3'b000, 0, 0, 1);
        checkImm("bad_imm", IMM_I);
        checkOutput("bad_fetch", S_FGO);
        checkOutput("bad_decode", S_DECODE);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            zero = i[1];
            checkOutput($sformatf("bad_error%0d", i), S_ERROR);
        end
        reset = 1;
        checkOutput("bad_in_reset", S_IDLE);
        applyStimulus(0, 7'b0110011, 3'b000, 0, 0, 0);
        checkOutput("bad_after_reset", S_FWAIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sequences one shared ALU, one unified memory port and the immediate sign extender across fetch, decode, execute, memory and writeback. It drives the `imm_src_t` select for the extender and every enable and mux select in the datapath. It stalls on a memory-ready handshake.

## Interface
Parameters:
- none (encodings fixed by `defines.svh`)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  `instr[6:0]` from instruction register
- `funct3`  in  3  `instr[14:12]`
- `funct7b5`  in  1  `instr[30]`
- `zero`  in  1  ALU zero flag (current cycle)
- `mem_ready`  in  1  memory completes access this cycle
- `pc_write`  out  1  PC load enable
- `adr_src`  out  1  memory address: 0=PC, 1=ALUOut
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  write strobe (qualified by `mem_req`)
- `ir_write`  out  1  load IR and OldPC
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `alu_src_a`  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero
- `alu_src_b`  out  2  00=RD2, 01=ImmExt, 10=constant 4
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `imm_src`  out  `imm_src_t`  extender select
- `illegal`  out  1  sticky unsupported-opcode flag

## Operation
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type
  - 0010011 I-ALU
  - 1100011 beq/bne
  - 1101111 jal
  - 0110111 lui
- `imm_src` is combinational from `op` only, with no dependence on state:
  - I for lw and I-ALU
  - S for sw
  - B for branches
  - J for jal
  - U for lui
  - otherwise IMM_I
- States, transitions and asserted outputs. Any output not listed is 0; selects default to 00. "Stay" means the state holds until the stated condition.
  - FETCH: `mem_req`, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
    - While `mem_ready`=0: stay.
    - On `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, add (precomputes branch/jump target into ALUOut).
    - lw/sw → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - branch → BRANCH
    - jal → JAL
    - lui → EXECU
    - other → ERROR
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: `mem_req`, `adr_src`=1. Stay until `mem_ready`, then MEMWB.
  - MEMWB: `result_src`=01, `reg_write`. Then FETCH.
  - MEMWRITE: `mem_req`, `mem_write`, `adr_src`=1. Stay until `mem_ready`, then FETCH.
  - EXECR: `alu_src_a`=10, `alu_src_b`=00, ALU decode. Then ALUWB.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, ALU decode. Then ALUWB.
  - EXECU: `alu_src_a`=11, `alu_src_b`=01, add. Then ALUWB.
  - ALUWB: `result_src`=00, `reg_write`. Then FETCH.
  - BRANCH: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00.
    - `pc_write` = `zero` XOR `funct3[0]` (beq when 0, bne when 1).
    - Then FETCH.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1. Then ALUWB, which writes PC+4 to rd.
  - ERROR: all enables 0, `illegal`=1. Stays until `reset`.
- ALU decode in EXECR/EXECI, by `funct3`:
  - 000: sub only when EXECR and `funct7b5`=1; otherwise add
  - 010: slt
  - 110: or
  - 111: and
  - other: add
- Branch `funct3` values other than 000/001 are treated per `funct3[0]`. No trap is raised.

## Timing
- `reset` high at an edge puts the FSM in FETCH. This holds even mid-instruction or mid-memory-stall; the pending access is abandoned.
- Output values while in reset:
  - all enables 0
  - `mem_req`=0
  - `illegal`=0
  - selects 00
  - `alu_control`=000
- After `reset` deasserts, outputs follow FETCH.
- Outputs are Moore-style, decoded from the state register. The exceptions are Mealy on inputs:
  - FETCH `ir_write`/`pc_write` depend on `mem_ready`.
  - BRANCH `pc_write` depends on `zero` and `funct3[0]`.
- Minimum cycles per instruction with `mem_ready` tied high:
  - lw 5
  - sw 4
  - R 4
  - I 4
  - lui 4
  - jal 4
  - branch 3
- Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_req` stays high and the address select stays stable for the entire stall.
- `ir_write` and `pc_write` pulse for exactly one cycle per instruction fetch.

## Test plan
- Reset mid-MEMREAD with `mem_ready`=0 → next cycle is FETCH; `reg_write`=0; `illegal`=0.
- lw `0x0080A283`, `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `imm_src`=IMM_I. `reg_write`=1 only in cycle 5, with `result_src`=01.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_req`/`mem_write`/`adr_src`=1 held for 4 cycles, then FETCH. `imm_src`=IMM_S. `reg_write` never 1.
- sub `0x40208133` → EXECR with `alu_control`=001. addi with `funct7b5`=1 → `alu_control`=000.
- Branches, each 3 cycles:
  - beq with `zero`=1 → `pc_write`=1 in BRANCH.
  - beq with `zero`=0 → `pc_write`=0.
  - bne with `zero`=0 → `pc_write`=1.
- Undefined opcode 0x7F → ERROR after DECODE. `illegal`=1 is held with no enables for 10 cycles and clears only on `reset`.
